// File: rtl/dac_sample_formatter.sv
// rtl/dac_sample_formatter.sv - multi-channel gain/offset/saturate DAC sample formatter and serialiser
//
// Accepts one frame of NCH signed samples per in_valid/in_ready handshake. The frame's
// gain and offset are captured with it. Each channel is then scaled, offset, range-limited
// and converted to offset-binary, and the channels are issued one per clock on the DAC bus.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  frame handshake
//   in_data         NCH*IN_W frame, channel k at [k*IN_W +: IN_W]
//   gain            unsigned Q1.(GAIN_W-1) gain, sampled at acceptance
//   offset          signed offset in output LSBs, sampled at acceptance
//   mute            forces mid-scale on the output stage
//   dadata          registered offset-binary DAC code
//   dac_valid       dadata carries a new sample this cycle
//   dac_ch          channel index of dadata
//   clip            sample was out of range (qualified by dac_valid)
//
// Build option: define DACFMT_SAT_EN to clamp out-of-range sums; otherwise they wrap.
`timescale 1ns/1ps
module dac_sample_formatter #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int GAIN_W = 8,
  parameter int NCH    = 2,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*IN_W-1:0]   in_data,
  input  logic [GAIN_W-1:0]     gain,
  input  logic [OUT_W-1:0]      offset,
  input  logic                  mute,
  output logic [OUT_W-1:0]      dadata,
  output logic                  dac_valid,
  output logic [CH_W-1:0]       dac_ch,
  output logic                  clip
);

  localparam int PW    = IN_W + GAIN_W + 1;
  localparam int SUM_W = ((PW > OUT_W) ? PW : OUT_W) + 1;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);
  localparam logic [OUT_W-1:0] MID     = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MAX_C   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_C   = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, next_state;
  logic [CH_W-1:0]     ch_cnt, next_cnt;
  logic                ready_q, ready_d;
  logic                accept, issue;

  logic [NCH*IN_W-1:0] hold_data;
  logic [GAIN_W-1:0]   hold_gain;
  logic [OUT_W-1:0]    hold_offset;

  logic                       s1_valid;
  logic [CH_W-1:0]            s1_ch;
  logic signed [PW-1:0]       s1_scaled;
  logic signed [OUT_W-1:0]    s1_offset;

  logic signed [IN_W-1:0]     sample_s;
  logic signed [GAIN_W:0]     gain_s;
  logic signed [PW-1:0]       prod;
  logic signed [SUM_W-1:0]    sum;
  logic [SUM_W-OUT_W:0]       sum_top;
  logic                       ovf;
  logic [OUT_W-1:0]           limited;

  // State register. in_ready is registered so that it stays low through reset and
  // rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch_cnt  <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= next_state;
      ch_cnt  <= next_cnt;
      ready_q <= ready_d;
    end
  end

  // Next state. A new frame may be accepted on the same edge that issues the last
  // channel of the current one, which keeps the output stream bubble-free.
  always_comb begin
    next_state = state;
    next_cnt   = ch_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SHIFT;
          next_cnt   = '0;
        end
      end
      SHIFT: begin
        if (ch_cnt == LAST_CH) begin
          next_state = accept ? SHIFT : IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = ch_cnt + CH_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
    // With a single channel the last-channel cycle is the only SHIFT cycle, so the
    // early-ready path is disabled and in_ready drops for that one cycle.
    ready_d = (next_state == IDLE) || ((NCH > 1) && (next_cnt == LAST_CH));
  end

  // Outputs of the sequencer.
  always_comb begin
    in_ready = ready_q;
    accept   = in_valid & ready_q;
    issue    = (state == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data   <= '0;
      hold_gain   <= '0;
      hold_offset <= '0;
    end else if (accept) begin
      hold_data   <= in_data;
      hold_gain   <= gain;
      hold_offset <= offset;
    end
  end

  // Stage 1: signed sample times unsigned gain, then floor-shift back to sample scale.
  always_comb begin
    sample_s = $signed(hold_data[ch_cnt*IN_W +: IN_W]);
    gain_s   = $signed({1'b0, hold_gain});
    prod     = PW'(sample_s) * PW'(gain_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ch     <= '0;
      s1_scaled <= '0;
      s1_offset <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_ch     <= ch_cnt;
        s1_scaled <= prod >>> (GAIN_W - 1);
        s1_offset <= $signed(hold_offset);
      end
    end
  end

  // Stage 2 arithmetic. The sum is in range exactly when every bit from the output
  // MSB upward is a copy of the sign, so no magnitude comparators are needed.
  always_comb begin
    sum     = SUM_W'(s1_scaled) + SUM_W'(s1_offset);
    sum_top = sum[SUM_W-1:OUT_W-1];
    ovf     = !((&sum_top) || !(|sum_top));
`ifdef DACFMT_SAT_EN
    if (ovf) limited = sum[SUM_W-1] ? MIN_C : MAX_C;
    else     limited = sum[OUT_W-1:0];
`else
    limited = sum[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dadata    <= MID;
      dac_valid <= 1'b0;
      dac_ch    <= '0;
      clip      <= 1'b0;
    end else begin
      dac_valid <= s1_valid;
      if (s1_valid) begin
        dac_ch <= s1_ch;
        if (mute) begin
          dadata <= MID;
          clip   <= 1'b0;
        end else begin
          dadata <= {~limited[OUT_W-1], limited[OUT_W-2:0]};
          clip   <= ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_formatter.sv
// tb/tb_dac_sample_formatter.sv - self-checking bench for dac_sample_formatter at default parameters
`timescale 1ns/1ps
module tb_dac_sample_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  gain;
  logic [7:0]  offset;
  logic        mute;
  logic [7:0]  dadata;
  logic        dac_valid;
  logic [0:0]  dac_ch;
  logic        clip;

  always #5 clk = ~clk;

  dac_sample_formatter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .gain(gain), .offset(offset), .mute(mute),
    .dadata(dadata), .dac_valid(dac_valid), .dac_ch(dac_ch), .clip(clip)
  );

`ifdef DACFMT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [7:0] d0, d1, g, o;
    logic [7:0] e0, e1;
    logic       c0, c1;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] ed, input logic ech, input logic ec);
    chk({nm, "_valid"}, 32'(dac_valid), 32'd1);
    chk({nm, "_data"},  32'(dadata),    32'(ed));
    chk({nm, "_ch"},    32'(dac_ch),    32'(ech));
    chk({nm, "_clip"},  32'(clip),      32'(ec));
  endtask

  // Called one time unit after a rising edge; returns one time unit after the acceptance
  // edge with the frame inputs scrambled so a late resample would show up.
  task automatic send(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] g, input logic [7:0] o);
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
    chk("wait_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = {d1, d0};
    gain     = g;
    offset   = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~{d1, d0};
    gain     = ~g;
    offset   = ~o;
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h80, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h00, 8'hFF, 8'h00, SAT ? 8'hFF : 8'h7D, 8'h80, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'hFF, 8'h80, 8'h05, 8'h95, 8'h84, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 8'h40, 8'h00, 8'h7F, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 8'hFF, 8'h00, SAT ? 8'h00 : 8'h81, SAT ? 8'hFF : 8'h7D, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h10, 8'h80, 8'hF6, 8'h76, 8'h86, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 8'h80, 8'h7F, SAT ? 8'hFF : 8'h7E, 8'h7F, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h80, 8'h80, 1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    gain     = '0;
    offset   = '0;
    mute     = 1'b0;

    #23;
    chk("rst_ready", 32'(in_ready),  32'd0);
    chk("rst_data",  32'(dadata),    32'h80);
    chk("rst_valid", 32'(dac_valid), 32'd0);
    chk("rst_ch",    32'(dac_ch),    32'd0);
    chk("rst_clip",  32'(clip),      32'd0);
    #4 rst_n = 1'b1;
    #3;
    chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(in_ready), 32'd1);

    // Table vectors: one frame each, both channels checked at E+2 and E+3.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].d0, vecs[v].d1, vecs[v].g, vecs[v].o);
      @(posedge clk); #1;
      chk($sformatf("v%0d_gap", v), 32'(dac_valid), 32'd0);
      @(posedge clk); #1;
      chk_out($sformatf("v%0d_ch0", v), vecs[v].e0, 1'b0, vecs[v].c0);
      @(posedge clk); #1;
      chk_out($sformatf("v%0d_ch1", v), vecs[v].e1, 1'b1, vecs[v].c1);
    end

    // Back-to-back: three frames with in_valid held high.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = {8'h20, 8'h10};
    gain     = 8'h80;
    offset   = 8'h00;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c <= 4) chk($sformatf("b2b_ready%0d", c), 32'(in_ready), 32'(c % 2));
      chk($sformatf("b2b_valid%0d", c), 32'(dac_valid), 32'((c >= 2 && c <= 7) ? 1 : 0));
      if (c >= 2 && c <= 7) begin
        chk($sformatf("b2b_ch%0d", c),   32'(dac_ch), 32'((c - 2) % 2));
        chk($sformatf("b2b_data%0d", c), 32'(dadata), (c % 2 == 0) ? 32'h90 : 32'hA0);
      end
      if (c == 4) in_valid = 1'b0;
    end

    // Mute one sample of a frame whose ch1 would otherwise clip.
    send(8'h10, 8'h7F, 8'hFF, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_out("mute_before", 8'h9F, 1'b0, 1'b0);
    mute = 1'b1;
    @(posedge clk); #1;
    chk_out("mute_hit", 8'h80, 1'b1, 1'b0);
    mute = 1'b0;
    send(8'h7F, 8'h10, 8'hFF, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_out("mute_after0", SAT ? 8'hFF : 8'h7D, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_out("mute_after1", 8'h9F, 1'b1, 1'b0);

    // Reset in the middle of a frame, then a clean frame afterwards.
    send(8'h10, 8'h20, 8'h80, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_out("mid_ch0", 8'h90, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data",  32'(dadata),    32'h80);
    chk("mid_rst_valid", 32'(dac_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd0);
    chk("mid_rst_clip",  32'(clip),      32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold_valid", 32'(dac_valid), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(in_ready),  32'd1);
    chk("post_rst_idle",  32'(dac_valid), 32'd0);
    send(8'h30, 8'h40, 8'h80, 8'h00);
    @(posedge clk); #1;
    chk("post_gap", 32'(dac_valid), 32'd0);
    @(posedge clk); #1;
    chk_out("post_ch0", 8'hB0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_out("post_ch1", 8'hC0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
